// File: rtl/arith_unit_if.sv
// Operand/result bundle for the accumulator add/subtract unit.
// The master drives operands; the slave returns registered result and flags.
interface arith_unit_if #(
    parameter int NB_DATA = 16
);
    logic               valid;
    logic [NB_DATA-1:0] acc;
    logic [NB_DATA-1:0] data;
    logic               op;
    logic               res_valid;
    logic [NB_DATA-1:0] res;
    logic               carry;
    logic               ovf;
    logic               zero;
    logic               neg;

    modport master (
        output valid, acc, data, op,
        input  res_valid, res, carry, ovf, zero, neg
    );

    modport slave (
        input  valid, acc, data, op,
        output res_valid, res, carry, ovf, zero, neg
    );
endinterface

// File: rtl/arith_unit.sv
// Two's-complement add/subtract on one NB_DATA+1 adder.
// Result and status flags are registered with one cycle of latency.
module arith_unit #(
    parameter int NB_DATA = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    arith_unit_if.slave  bus
);
    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA-1:0] b_opnd;
    logic [NB_DATA:0]   sum;
    logic [NB_DATA-1:0] res_next;
    logic               carry_next;
    logic               ovf_next;

    // Subtract reuses the adder as acc + ~data + 1.
    always_comb begin
        b_opnd     = bus.op ? ~bus.data : bus.data;
        sum        = {1'b0, bus.acc} + {1'b0, b_opnd}
                   + {{NB_DATA{1'b0}}, bus.op};
        res_next   = sum[MSB:0];
        carry_next = bus.op ? ~sum[NB_DATA] : sum[NB_DATA];
        ovf_next   = (bus.acc[MSB] == b_opnd[MSB])
                   && (res_next[MSB] != bus.acc[MSB]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.res_valid <= 1'b0;
            bus.res       <= '0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
            bus.neg       <= 1'b0;
        end else begin
            bus.res_valid <= bus.valid;
            if (bus.valid) begin
                bus.res   <= res_next;
                bus.carry <= carry_next;
                bus.ovf   <= ovf_next;
                bus.zero  <= (res_next == '0);
                bus.neg   <= res_next[MSB];
            end
        end
    end
endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit against an integer reference model.
// Covers directed vectors, random traffic, holds and asynchronous reset.
module tb_arith_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [20:0] last_exp;

    arith_unit_if #(.NB_DATA(16)) u ();

    arith_unit #(.NB_DATA(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] model(
        input logic [15:0] a,
        input logic [15:0] d,
        input logic        op
    );
        int unsigned ua;
        int unsigned ud;
        int          sa;
        int          sd;
        int          sr;
        logic [15:0] r;
        logic        c;
        logic        v;
        ua = a;
        ud = d;
        sa = $signed(a);
        sd = $signed(d);
        if (!op) begin
            r  = 16'((ua + ud) & 32'hFFFF);
            c  = (ua + ud) > 32'hFFFF;
            sr = sa + sd;
        end else begin
            r  = 16'((ua - ud) & 32'hFFFF);
            c  = ua < ud;
            sr = sa - sd;
        end
        v = (sr > 32767) || (sr < -32768);
        return {1'b1, r, c, v, r == 16'h0, r[15]};
    endfunction

    function automatic logic [20:0] observed();
        return {u.res_valid, u.res, u.carry,
                u.ovf, u.zero, u.neg};
    endfunction

    task automatic drive(
        input logic        v,
        input logic [15:0] a,
        input logic [15:0] d,
        input logic        op
    );
        u.valid = v;
        u.acc   = a;
        u.data  = d;
        u.op    = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] got;
        u.valid = 1'b1;
        u.acc   = 16'h1234;
        u.data  = 16'h0001;
        u.op    = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 21'h0) begin
            errors++;
            $display("FAIL reset: got=%h want=%h", got, 21'h0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        u.valid = 1'b0;
        last_exp = 21'h0;
    endtask

    task automatic test_vectors();
        logic [15:0] va [6];
        logic [15:0] vd [6];
        logic        vo [6];
        logic [20:0] want [6];
        logic [20:0] got;
        va = '{16'h0001, 16'h8000, 16'h0006,
               16'h000F, 16'h0030, 16'h0005};
        vd = '{16'h0000, 16'hFFFF, 16'h0001,
               16'h0005, 16'h8016, 16'h0005};
        vo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        want = '{{1'b1, 16'h0001, 4'b0000},
                 {1'b1, 16'h7FFF, 4'b1100},
                 {1'b1, 16'h0007, 4'b0000},
                 {1'b1, 16'h000A, 4'b0000},
                 {1'b1, 16'h801A, 4'b1101},
                 {1'b1, 16'h0000, 4'b0010}};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, va[i], vd[i], vo[i]);
            got = observed();
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL vector%0d: got=%h want=%h",
                         i, got, want[i]);
            end
        end
        last_exp = want[5];
    endtask

    task automatic test_hold();
        logic [20:0] got;
        logic [20:0] want;
        want = {1'b0, last_exp[19:0]};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
            got = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL hold%0d: got=%h want=%h",
                         i, got, want);
            end
        end
        last_exp = want;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] d;
        logic        op;
        logic        v;
        logic [20:0] got;
        for (int i = 0; i < 300; i++) begin
            a  = 16'($urandom);
            d  = 16'($urandom);
            op = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            if (i % 10 == 0) d = a;
            drive(v, a, d, op);
            if (v) last_exp = model(a, d, op);
            else   last_exp = {1'b0, last_exp[19:0]};
            got = observed();
            checks++;
            if (got !== last_exp) begin
                errors++;
                $display("FAIL random%0d: got=%h want=%h",
                         i, got, last_exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] d;
        logic        op;
        logic [20:0] got;
        for (int i = 0; i < 20; i++) begin
            a  = 16'($urandom) | 16'h8000;
            d  = (i % 2 == 0) ? 16'($urandom) : 16'hFFFF;
            op = i[0];
            drive(1'b1, a, d, op);
            last_exp = model(a, d, op);
            got = observed();
            checks++;
            if (got !== last_exp) begin
                errors++;
                $display("FAIL b2b%0d: got=%h want=%h",
                         i, got, last_exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [20:0] got;
        logic [20:0] want;
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== 21'h0) begin
            errors++;
            $display("FAIL async_rst: got=%h want=%h",
                     got, 21'h0);
        end
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== 21'h0) begin
            errors++;
            $display("FAIL rst_held: got=%h want=%h",
                     got, 21'h0);
        end
        #2;
        rst_n = 1'b1;
        drive(1'b1, 16'h0003, 16'h0009, 1'b1);
        want = model(16'h0003, 16'h0009, 1'b1);
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL post_rst: got=%h want=%h",
                     got, want);
        end
        u.valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        u.valid = 1'b0;
        u.acc   = '0;
        u.data  = '0;
        u.op    = 1'b0;
        #1;
        test_reset();
        test_vectors();
        test_hold();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
